// File: rtl/reg_array_sequencer.sv
// Command sequencer for a column of bit-sliced register rows.
// Commands are buffered in a small FIFO and retired one per execute step;
// every array control output is registered and is zero outside an execute step.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no command executing; outputs quiet
// S_EXEC    | single-cycle command on the array (ALU, CLR, CLC, MOV no-op)
// S_MOV_CLR | first half of MOV: clear the destination row
// S_MOV_OR  | second half of MOV: dst <= dst OR src
module reg_array_sequencer #(
    parameter int NUM_ROWS   = 8,
    parameter int ROW_AW     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ROW_AW-1:0]     cmd_dst,
    input  logic [ROW_AW-1:0]     cmd_srca,
    input  logic [ROW_AW-1:0]     cmd_srcb,
    input  logic                  c_out_msb,
    output logic                  c_in_lsb,
    output logic [NUM_ROWS-1:0]   rd_sel_up,
    output logic [NUM_ROWS-1:0]   rd_sel_dn,
    output logic [NUM_ROWS-1:0]   wr_sel_up,
    output logic [NUM_ROWS-1:0]   wr_sel_dn,
    output logic [NUM_ROWS-1:0]   wr_en,
    output logic [4*NUM_ROWS-1:0] op_fa,
    output logic                  carry_flag,
    output logic                  op_done,
    output logic                  busy
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = 3 + 3 * ROW_AW;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDC = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MOV_CLR, S_MOV_OR} state_t;

    logic [CW-1:0]  mem [FIFO_DEPTH];
    logic [FAW-1:0] wr_ptr, rd_ptr;
    logic [FAW:0]   count;
    logic           fifo_full, fifo_empty, push, pop;
    logic [CW-1:0]  head;

    state_t         state_q, state_d;
    logic [CW-1:0]  cur_q, cur_d;
    logic           carry_q, carry_d;

    logic [2:0]        cur_op, head_op, nxt_op;
    logic [ROW_AW-1:0] head_dst, head_srcb, nxt_dst, nxt_srca, nxt_srcb;

    logic              step_route, step_wr, step_cin, done_d;
    logic [ROW_AW-1:0] step_a;
    logic [3:0]        step_fa;
    logic [NUM_ROWS-1:0]   rd_up_d, rd_dn_d, wr_up_d, wr_dn_d, wr_en_d;
    logic [4*NUM_ROWS-1:0] op_fa_d;
    logic [NUM_ROWS-1:0]   rd_up_q, rd_dn_q, wr_up_q, wr_dn_q, wr_en_q;
    logic [4*NUM_ROWS-1:0] op_fa_q;
    logic                  cin_q, done_q;

    assign fifo_full  = (count == (FAW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = cmd_valid && !fifo_full;
    assign head       = mem[rd_ptr];

    assign cur_op    = cur_q[CW-1 -: 3];
    assign head_op   = head[CW-1 -: 3];
    assign head_dst  = head[3*ROW_AW-1 -: ROW_AW];
    assign head_srcb = head[ROW_AW-1:0];
    assign nxt_op    = cur_d[CW-1 -: 3];
    assign nxt_dst   = cur_d[3*ROW_AW-1 -: ROW_AW];
    assign nxt_srca  = cur_d[2*ROW_AW-1 -: ROW_AW];
    assign nxt_srcb  = cur_d[ROW_AW-1:0];

    // Command storage; contents need no reset because count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_dst, cmd_srca, cmd_srcb};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next state, command pop and carry update for the step now on the array.
    always_comb begin
        cur_d   = cur_q;
        carry_d = carry_q;
        pop     = 1'b0;
        state_d = (state_q == S_MOV_CLR) ? S_MOV_OR : S_IDLE;
        if (state_q == S_EXEC) begin
            if (cur_op == OP_ADD || cur_op == OP_ADDC) carry_d = c_out_msb;
            else if (cur_op == 3'd7)                   carry_d = 1'b0;
        end
        if (!fifo_empty && (state_q == S_IDLE || state_q == S_EXEC || state_q == S_MOV_OR)) begin
            pop     = 1'b1;
            cur_d   = head;
            state_d = (head_op == OP_MOV && head_dst != head_srcb) ? S_MOV_CLR : S_EXEC;
        end
    end

    // Decode the upcoming step into row selects; carry-in forwards the fresh carry.
    always_comb begin
        step_route = 1'b0;
        step_wr    = 1'b0;
        step_cin   = 1'b0;
        step_a     = nxt_srca;
        step_fa    = 4'b0000;
        case (state_d)
            S_EXEC: begin
                case (nxt_op)
                    OP_ADD:  begin step_route = 1'b1; step_fa = 4'b0001; end
                    OP_ADDC: begin step_route = 1'b1; step_fa = 4'b0001; step_cin = carry_d; end
                    OP_AND:  begin step_route = 1'b1; step_fa = 4'b0010; end
                    OP_XOR:  begin step_route = 1'b1; step_fa = 4'b0100; end
                    OP_OR:   begin step_route = 1'b1; step_fa = 4'b1000; end
                    OP_CLR:  step_wr = 1'b1;
                    default: ;
                endcase
            end
            S_MOV_CLR: step_wr = 1'b1;
            S_MOV_OR:  begin step_route = 1'b1; step_a = nxt_dst; step_fa = 4'b1000; end
            default: ;
        endcase
        done_d = (state_d == S_EXEC) || (state_d == S_MOV_OR);
        for (int r = 0; r < NUM_ROWS; r++) begin
            rd_up_d[r] = step_route && (nxt_srcb == ROW_AW'(r)) && (nxt_srcb <= step_a);
            rd_dn_d[r] = step_route && (nxt_srcb == ROW_AW'(r)) && (nxt_srcb >  step_a);
            wr_up_d[r] = step_route && (step_a == ROW_AW'(r)) && (step_a <= nxt_dst);
            wr_dn_d[r] = step_route && (step_a == ROW_AW'(r)) && (step_a >  nxt_dst);
            wr_en_d[r] = (step_route || step_wr) && (nxt_dst == ROW_AW'(r));
            op_fa_d[4*r +: 4] = (step_route && step_a == ROW_AW'(r)) ? step_fa : 4'b0000;
        end
    end

    // State, command, carry and registered array controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            carry_q <= 1'b0;
            rd_up_q <= '0;
            rd_dn_q <= '0;
            wr_up_q <= '0;
            wr_dn_q <= '0;
            wr_en_q <= '0;
            op_fa_q <= '0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            carry_q <= carry_d;
            rd_up_q <= rd_up_d;
            rd_dn_q <= rd_dn_d;
            wr_up_q <= wr_up_d;
            wr_dn_q <= wr_dn_d;
            wr_en_q <= wr_en_d;
            op_fa_q <= op_fa_d;
            cin_q   <= step_cin;
            done_q  <= done_d;
        end
    end

    // Reset silences the array in the very cycle it is asserted.
    assign rd_sel_up  = rst ? '0 : rd_up_q;
    assign rd_sel_dn  = rst ? '0 : rd_dn_q;
    assign wr_sel_up  = rst ? '0 : wr_up_q;
    assign wr_sel_dn  = rst ? '0 : wr_dn_q;
    assign wr_en      = rst ? '0 : wr_en_q;
    assign op_fa      = rst ? '0 : op_fa_q;
    assign c_in_lsb   = !rst && cin_q;
    assign op_done    = !rst && done_q;
    assign carry_flag = !rst && carry_q;
    assign busy       = !rst && (!fifo_empty || state_q != S_IDLE);
    assign cmd_ready  = !fifo_full;

endmodule

// File: doc/reg_array_sequencer.md
Name: reg_array_sequencer

Overview:
Command-driven controller for a column of bit-sliced register rows, rows 0..NUM_ROWS-1 with row 0 at the bottom.
- Each row is a word of reg_cell instances chained by carry.
- Buffers ALU commands in a small FIFO and executes them one at a time.
- Per executing cycle it drives the one-hot row selects for the up/down read and write buses, per-row op_fa, write enables and the LSB carry-in.
- Sits between the instruction front-end and the register array.

Parameters:
NUM_ROWS, 8, number of register rows in the array
ROW_AW, 3, row index width, equal to clog2(NUM_ROWS)
FIFO_DEPTH, 4, command FIFO entries (power of two, at least 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_op  in  3  0 ADD, 1 ADDC, 2 AND, 3 XOR, 4 OR, 5 MOV, 6 CLR, 7 CLC
cmd_dst  in  ROW_AW  destination row
cmd_srca  in  ROW_AW  source A row (its FA produces the result)
cmd_srcb  in  ROW_AW  source B row (driven onto a read bus)
c_out_msb  in  1  carry out of the array's MSB cell
c_in_lsb  out  1  carry into the array's LSB cell
rd_sel_up  out  NUM_ROWS  one-hot read select, up bus
rd_sel_dn  out  NUM_ROWS  one-hot read select, down bus
wr_sel_up  out  NUM_ROWS  one-hot write-driver select, up bus
wr_sel_dn  out  NUM_ROWS  one-hot write-driver select, down bus
wr_en  out  NUM_ROWS  per-row write enable
op_fa  out  4*NUM_ROWS  per-row one-hot FA op; row r uses bits [4r+3:4r] (bit0 sum, bit1 and, bit2 xor, bit3 or)
carry_flag  out  1  stored carry
op_done  out  1  one-cycle pulse when a command retires
busy  out  1  FIFO non-empty or sequencer not IDLE

Behaviour:
- Reset: clk and rst form the single clock/reset pair; reset is synchronous and active-high. It empties the FIFO and forces state to IDLE. carry_flag=0, op_done=0, busy=0, cmd_ready=1, and all select/enable/op_fa/c_in_lsb outputs are 0. Reset mid-operation aborts the command, and wr_en is 0 in the reset cycle.
- FIFO:
  - Push when cmd_valid and cmd_ready. cmd_ready = !full.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Pop occurs when the FIFO is non-empty and the FSM is IDLE or in its final cycle of a command.
- Array control outputs are registered and are all 0 in any cycle without an execute step. Only one row bit is set per one-hot vector.
- Bus routing, per execute step:
  - Read bus: srcb <= srca uses rd_sel_up[srcb]; otherwise rd_sel_dn[srcb].
  - Write bus: srca <= dst uses wr_sel_up[srca]; otherwise wr_sel_dn[srca].
  - wr_en[dst]=1. op_fa is non-zero only for row srca.
- FSM states: IDLE, EXEC, MOV_CLR, MOV_OR.
  - IDLE: on pop, load the command and go to EXEC, except MOV with dst != srcb, which goes to MOV_CLR.
  - EXEC: one cycle, then pop the next command (EXEC again or MOV_CLR) or return to IDLE.
  - ADD: op_fa=0001, c_in_lsb=0.
  - ADDC: op_fa=0001, c_in_lsb=carry_flag.
  - AND: 0010. XOR: 0100. OR: 1000.
  - ADD and ADDC load carry_flag <= c_out_msb at the end of EXEC.
  - CLR: wr_en[dst] only; no selects, op_fa=0.
  - CLC: no array activity; carry_flag <= 0.
  - MOV with dst==srcb: no array activity.
  - MOV_CLR: behaves as CLR on dst, then goes to MOV_OR.
  - MOV_OR: behaves as OR with srca=dst, srcb=src, then pops or returns to IDLE.
- op_done pulses in the final execute cycle of each command.
- Latency: a command accepted in cycle N into an empty FIFO with the FSM IDLE has its first execute cycle in N+2. Single-cycle commands then sustain 1 per cycle; MOV takes 2.
- Consecutive commands commit before the next executes, so no hazard stalls are required. An ADDC immediately after an ADD uses the updated carry_flag.

Test Plan:
- ADD dst=5, srca=2, srcb=1 -> one cycle with rd_sel_up=0x02, wr_sel_up=0x04, wr_en=0x20, op_fa row2=0001, c_in_lsb=0, op_done=1. With c_out_msb=1, carry_flag=1 next cycle.
- XOR dst=0, srca=3, srcb=6 -> rd_sel_dn=0x40, wr_sel_dn=0x08, wr_en=0x01, op_fa row3=0100. All up-bus vectors 0.
- ADD (c_out_msb=1), then ADDC, then CLC back-to-back -> consecutive execute cycles; ADDC drives c_in_lsb=1; carry_flag=0 after CLC. Three op_done pulses.
- MOV dst=4, srcb=7 -> cycle 1: wr_en=0x10, all else 0. Cycle 2: rd_sel_dn=0x80, wr_sel_up=0x10, op_fa row4=1000, op_done=1.
- Push 5 commands with the FSM stalled by a leading MOV -> cmd_ready low while the FIFO holds 4. All 5 execute in order, and busy drops 1 cycle after the last op_done.
- Assert rst during MOV_CLR -> wr_en and all outputs 0 in that cycle. FIFO empty, carry_flag=0, and the MOV_OR step never occurs.
